// File: rtl/water_dispenser_pkg.sv
// Shared definitions for the water dispenser: FSM state encodings, default
// timing constants and a width helper.
package water_dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DISPENSING = 2'd1,
    COOLDOWN   = 2'd2
  } state_e;

  localparam int DEFAULT_DISPENSE_CYCLES = 50_000_000;
  localparam int DEFAULT_COOLDOWN_CYCLES = 5_000_000;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero and flags when it gets there.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Decrement is gated by zero so the count can never wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/dispense_controller.sv
// Timed water-valve controller: one dispense per start request, abortable,
// followed by a lockout period. All outputs come straight from flops.
module dispense_controller
  import water_dispenser_pkg::*;
#(
  parameter int DISPENSE_CYCLES = DEFAULT_DISPENSE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES,
  parameter int COUNTER_WIDTH   = $clog2(max_cycles(DISPENSE_CYCLES, COOLDOWN_CYCLES) + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_pulse,
  input  logic                     stop_pulse,
  output logic                     valve_open,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [COUNTER_WIDTH-1:0] remaining
);

  localparam logic [COUNTER_WIDTH-1:0] DISPENSE_LOAD = COUNTER_WIDTH'(DISPENSE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] COOLDOWN_LOAD =
    COUNTER_WIDTH'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);

  state_e state_reg, state_next;

  logic                     valve_reg, valve_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic [COUNTER_WIDTH-1:0] remaining_reg, remaining_next;

  logic                     cnt_load;
  logic [COUNTER_WIDTH-1:0] cnt_load_value;
  logic                     cnt_dec;
  logic [COUNTER_WIDTH-1:0] cnt_count;
  logic                     cnt_zero;

  // One counter times both the dispense window and the lockout that follows.
  down_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      valve_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      valve_reg     <= valve_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    valve_next     = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    remaining_next = '0;
    cnt_load       = 1'b0;
    cnt_load_value = DISPENSE_LOAD;
    cnt_dec        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A simultaneous stop cancels the start.
        if (start_pulse && !stop_pulse) begin
          state_next     = DISPENSING;
          cnt_load       = 1'b1;
          valve_next     = 1'b1;
          busy_next      = 1'b1;
          remaining_next = DISPENSE_LOAD;
        end
      end

      DISPENSING: begin
        if (stop_pulse || cnt_zero) begin
          done_next      = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_value = COOLDOWN_LOAD;
          if (COOLDOWN_CYCLES > 0) begin
            state_next = COOLDOWN;
            busy_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_dec        = 1'b1;
          valve_next     = 1'b1;
          busy_next      = 1'b1;
          remaining_next = cnt_count - 1'b1;
        end
      end

      COOLDOWN: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec   = 1'b1;
          busy_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign valve_open = valve_reg;
  assign busy       = busy_reg;
  assign done_pulse = done_reg;
  assign remaining  = remaining_reg;

endmodule

// File: doc/dispense_controller.md
DISPENSE_CONTROLLER -- requirements
Module: dispense_controller

Interface
REQ-001 Parameter DISPENSE_CYCLES, default 50_000_000, number of clock cycles valve_open stays high per dispense; SHALL be >= 1.
REQ-002 Parameter COOLDOWN_CYCLES, default 5_000_000, lockout cycles after each dispense; SHALL be >= 0.
REQ-003 Parameter COUNTER_WIDTH, default $clog2(max(DISPENSE_CYCLES, COOLDOWN_CYCLES)+1), width of the internal counter and of remaining.
REQ-004 clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start_pulse  input  1  single-cycle dispense request, typically a button falling-edge detect pulse.
REQ-007 stop_pulse  input  1  single-cycle abort request.
REQ-008 valve_open  output  1  registered valve drive; 1 = water flowing.
REQ-009 busy  output  1  registered; 1 while in DISPENSING or COOLDOWN.
REQ-010 done_pulse  output  1  registered; one-cycle pulse when a dispense ends, whether it times out or is aborted.
REQ-011 remaining  output  COUNTER_WIDTH  registered; cycles of dispense left; 0 outside DISPENSING.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DISPENSING and COOLDOWN.
REQ-013 In IDLE with start_pulse=1 and stop_pulse=0 sampled at edge N, the FSM SHALL be in DISPENSING after edge N, with valve_open=1, busy=1 and remaining=DISPENSE_CYCLES-1.
REQ-014 In DISPENSING, valve_open SHALL be high for exactly DISPENSE_CYCLES consecutive cycles, and remaining SHALL decrement by 1 per cycle down to 0.
REQ-015 On the edge after the cycle with remaining=0 in DISPENSING, the block SHALL set valve_open=0, pulse done_pulse=1 for one cycle and enter COOLDOWN, or IDLE if COOLDOWN_CYCLES=0.
REQ-016 stop_pulse=1 sampled in DISPENSING SHALL behave as in REQ-015 on that edge: valve closes, done_pulse pulses, and the FSM enters COOLDOWN (or IDLE); remaining SHALL become 0.
REQ-017 start_pulse and stop_pulse both 1 in IDLE: stop SHALL win and the FSM SHALL stay in IDLE.
REQ-018 start_pulse in DISPENSING or COOLDOWN SHALL be ignored, with no queuing and no timer restart.
REQ-019 stop_pulse in IDLE or COOLDOWN SHALL have no effect.
REQ-020 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles with busy=1 and valve_open=0, then return to IDLE with busy=0.
REQ-021 A start_pulse sampled on the first IDLE cycle after COOLDOWN SHALL be accepted per REQ-013.
REQ-022 The counter SHALL never wrap; decrementing below 0 SHALL be impossible by construction.
REQ-023 A start_pulse held high for several cycles SHALL start only one dispense, because REQ-018 ignores the extra cycles.

Reset
REQ-024 reset=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, valve_open=0, busy=0, done_pulse=0 and remaining=0.
REQ-025 Reset asserted mid-DISPENSING SHALL close the valve without a done_pulse.
REQ-026 After reset release, no dispense SHALL start without a new start_pulse.

Structure
REQ-027 State encodings (IDLE=2'd0, DISPENSING=2'd1, COOLDOWN=2'd2) SHALL live in the shared package water_dispenser_pkg, together with the default cycle constants.
REQ-028 One sub-module is natural: down_counter, which loads a value, decrements, and flags zero; it SHALL be reused for both the dispense and cooldown timing.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Verification (DISPENSE_CYCLES=4, COOLDOWN_CYCLES=3)
REQ-030 Start at edge 10 -> valve_open=1 on cycles 11-14, with remaining 3,2,1,0; done_pulse=1 on cycle 15; busy=1 on cycles 11-17; IDLE on cycle 18.
REQ-031 Start at edge 10, stop at edge 12 -> valve_open=0 and done_pulse=1 on cycle 13; COOLDOWN on cycles 13-15; busy=0 on cycle 16.
REQ-032 Start and stop together in IDLE -> valve_open stays 0 and busy stays 0.
REQ-033 Start at edge 10, plus extra starts at edges 12 and 16 -> a single 4-cycle dispense; a start at edge 18 opens the valve on cycle 19.
REQ-034 reset=0 driven mid-cycle during DISPENSING -> valve_open=0 before the next edge, with no done_pulse; after release, all outputs stay 0 until the next start.
REQ-035 COOLDOWN_CYCLES=0 build, start at edge 10 -> done_pulse=1 on cycle 15 and busy=0 on cycle 15; a start on cycle 15 is accepted.
